// File: rtl/seg_scan_rx_pkg.sv
// seg_scan_rx_pkg: segment constants, digit/sel codes and frame states shared by the scan driver and receiver
package seg_scan_rx_pkg;

    localparam logic [7:0] SEG_0 = 8'h7E;
    localparam logic [7:0] SEG_1 = 8'h30;
    localparam logic [7:0] SEG_2 = 8'h6D;
    localparam logic [7:0] SEG_3 = 8'h79;
    localparam logic [7:0] SEG_4 = 8'h33;
    localparam logic [7:0] SEG_5 = 8'h5B;
    localparam logic [7:0] SEG_6 = 8'h5F;
    localparam logic [7:0] SEG_7 = 8'h70;
    localparam logic [7:0] SEG_8 = 8'h7F;
    localparam logic [7:0] SEG_9 = 8'h7B;
    localparam logic [7:0] SEG_E = 8'h4F;

    localparam logic [3:0] DIG_E = 4'hE;

    localparam logic [1:0] SEL_TEN = 2'b01;
    localparam logic [1:0] SEL_ONE = 2'b10;

    localparam logic [6:0] VAL_NONE = 7'd127;

    typedef enum logic {W_TEN, W_ONE} state_e;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational segment-pattern to digit decoder
//   seg_i : 8-bit segment pattern (bit 7 expected 0)
//   dig_o : decoded digit 0-9, or DIG_E for the "E" pattern / unknown patterns
//   bad_o : high when seg_i is not one of the 11 known patterns
module seg7_decode
    import seg_scan_rx_pkg::*;
(
    input  logic [7:0] seg_i,
    output logic [3:0] dig_o,
    output logic       bad_o
);

    always_comb begin
        dig_o = DIG_E;
        bad_o = 1'b0;
        case (seg_i)
            SEG_0:   dig_o = 4'd0;
            SEG_1:   dig_o = 4'd1;
            SEG_2:   dig_o = 4'd2;
            SEG_3:   dig_o = 4'd3;
            SEG_4:   dig_o = 4'd4;
            SEG_5:   dig_o = 4'd5;
            SEG_6:   dig_o = 4'd6;
            SEG_7:   dig_o = 4'd7;
            SEG_8:   dig_o = 4'd8;
            SEG_9:   dig_o = 4'd9;
            SEG_E:   dig_o = DIG_E;
            default: bad_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_rx.sv
// seg_scan_rx: recovers a stable two-digit reading from a multiplexed 7-segment scan bus
//   clk, rst : system clock, synchronous active-high reset
//   seg, sel : scanned segment pattern and digit select (01 tens, 10 ones)
//   ten, one : last confirmed digits (DIG_E for E/unknown)
//   value    : ten*10+one, or 127 when either digit is not 0-9
//   valid    : confirmed frame held and not timed out
//   upd      : one-cycle pulse when ten/one/value change
//   err      : sticky illegal sel / unknown pattern flag
module seg_scan_rx
    import seg_scan_rx_pkg::*;
#(
    parameter int TIMEOUT       = 150000,
    parameter int STABLE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg,
    input  logic [1:0] sel,
    output logic [3:0] ten,
    output logic [3:0] one,
    output logic [6:0] value,
    output logic       valid,
    output logic       upd,
    output logic       err
);

    localparam int IW = $clog2(TIMEOUT + 1);
    localparam int MW = $clog2(STABLE_FRAMES + 1);

    logic [7:0]    seg_q;
    logic [1:0]    sel_q, sel_prev_q;
    logic          live_q;
    state_e        state_q, state_d;
    logic [3:0]    tens_q, tens_d;
    logic [7:0]    cand_q, cand_d;
    logic [MW-1:0] match_q, match_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [3:0]    ten_q, ten_d, one_q, one_d;
    logic [6:0]    value_q, value_d;
    logic          valid_q, valid_d, upd_q, upd_d, err_q, err_d;
    logic [3:0]    dig;
    logic          bad, cap, cap_ten, cap_one, illegal, tout, done, load;

    seg7_decode u_dec (
        .seg_i (seg_q),
        .dig_o (dig),
        .bad_o (bad)
    );

    // live_q masks the 00 that sel_q holds straight out of reset
    assign illegal = live_q && (sel_q == 2'b00 || sel_q == 2'b11);
    assign cap     = sel_q != sel_prev_q && (sel_q == SEL_TEN || sel_q == SEL_ONE);
    assign cap_ten = cap && sel_q == SEL_TEN;
    assign cap_one = cap && sel_q == SEL_ONE;
    assign done    = cap_one && state_q == W_ONE;
    // a capture on the timeout cycle wins: the counter clears instead
    assign tout    = idle_q == IW'(TIMEOUT) && !cap;

    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        cand_d  = cand_q;
        match_d = match_q;
        idle_d  = cap ? '0 : (idle_q == IW'(TIMEOUT) ? idle_q : idle_q + IW'(1));
        if (cap_ten) begin
            tens_d  = dig;
            state_d = W_ONE;
        end
        if (done) begin
            state_d = W_TEN;
            cand_d  = {tens_q, dig};
            match_d = {tens_q, dig} != cand_q ? MW'(1) :
                      match_q == MW'(STABLE_FRAMES) ? match_q : match_q + MW'(1);
        end
        if (tout) begin
            state_d = W_TEN;
            match_d = '0;
        end
    end

    assign load    = done && match_d == MW'(STABLE_FRAMES);
    assign ten_d   = load ? cand_d[7:4] : ten_q;
    assign one_d   = load ? cand_d[3:0] : one_q;
    assign value_d = !load ? value_q :
                     (cand_d[7:4] <= 4'd9 && cand_d[3:0] <= 4'd9) ?
                     7'(cand_d[7:4]) * 7'd10 + 7'(cand_d[3:0]) : VAL_NONE;
    assign valid_d = load ? 1'b1 : (tout ? 1'b0 : valid_q);
    assign upd_d   = load && (!valid_q || cand_d != {ten_q, one_q});
    assign err_d   = err_q || illegal || (cap && bad);

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q      <= '0;
            sel_q      <= 2'b00;
            sel_prev_q <= 2'b00;
            live_q     <= 1'b0;
            state_q    <= W_TEN;
            tens_q     <= '0;
            cand_q     <= '0;
            match_q    <= '0;
            idle_q     <= '0;
            ten_q      <= '0;
            one_q      <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            upd_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            seg_q      <= seg;
            sel_q      <= sel;
            sel_prev_q <= sel_q;
            live_q     <= 1'b1;
            state_q    <= state_d;
            tens_q     <= tens_d;
            cand_q     <= cand_d;
            match_q    <= match_d;
            idle_q     <= idle_d;
            ten_q      <= ten_d;
            one_q      <= one_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            upd_q      <= upd_d;
            err_q      <= err_d;
        end
    end

    assign ten   = ten_q;
    assign one   = one_q;
    assign value = value_q;
    assign valid = valid_q;
    assign upd   = upd_q;
    assign err   = err_q;

endmodule

// File: tb/tb_seg_scan_rx.sv
// tb_seg_scan_rx: directed and randomized checks of seg_scan_rx against a frame-history reference model
module tb_seg_scan_rx;

    localparam int TO = 60;
    localparam int SF = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seg;
    logic [1:0] sel;
    logic [3:0] ten, one;
    logic [6:0] value;
    logic       valid, upd, err;

    always #5 clk = ~clk;

    seg_scan_rx #(.TIMEOUT(TO), .STABLE_FRAMES(SF)) dut (
        .clk   (clk),
        .rst   (rst),
        .seg   (seg),
        .sel   (sel),
        .ten   (ten),
        .one   (one),
        .value (value),
        .valid (valid),
        .upd   (upd),
        .err   (err)
    );

    logic [7:0] pats [11] = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B,
                              8'h5F, 8'h70, 8'h7F, 8'h7B, 8'h4F};
    logic [7:0] pool [4]  = '{8'h7E, 8'h30, 8'h4F, 8'h79};

    int n_chk = 0, n_pass = 0, upd_cnt = 0, exp_upd = 0, m_idle = 0;
    logic [1:0] m_last;
    bit         m_have, m_valid, m_err;
    logic [3:0] m_tens, m_ten, m_one;
    logic [7:0] frames [$];

    always @(posedge clk) begin
        #1;
        if (rst) upd_cnt = 0;
        else if (upd) upd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void dec(input logic [7:0] p, output logic [3:0] d, output bit b);
        d = 4'hE;
        b = 1'b1;
        for (int i = 0; i < 11; i++)
            if (p == pats[i]) begin
                d = (i == 10) ? 4'hE : 4'(i);
                b = 1'b0;
            end
    endfunction

    function automatic int m_value();
        return (m_ten < 10 && m_one < 10) ? m_ten * 10 + m_one : 127;
    endfunction

    task automatic model(input logic [1:0] s, input logic [7:0] p);
        logic [3:0] d;
        bit b, same;
        logic [7:0] f;
        if (s == 2'b00 || s == 2'b11) m_err = 1'b1;
        else if (s != m_last) begin
            dec(p, d, b);
            m_idle = 0;
            if (b) m_err = 1'b1;
            if (s == 2'b01) begin
                m_tens = d;
                m_have = 1'b1;
            end else if (m_have) begin
                m_have = 1'b0;
                f = {m_tens, d};
                frames.push_back(f);
                if (frames.size() >= SF) begin
                    same = 1'b1;
                    for (int k = 1; k < SF; k++)
                        if (frames[frames.size() - 1 - k] != f) same = 1'b0;
                    if (same) begin
                        if (!m_valid || f != {m_ten, m_one}) exp_upd++;
                        m_ten   = f[7:4];
                        m_one   = f[3:0];
                        m_valid = 1'b1;
                    end
                end
            end
        end
        m_last = s;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ten"}, ten, m_ten);
        chk({tag, ".one"}, one, m_one);
        chk({tag, ".value"}, value, m_value());
        chk({tag, ".valid"}, valid, m_valid);
        chk({tag, ".err"}, err, m_err);
        chk({tag, ".upd_cnt"}, upd_cnt, exp_upd);
    endtask

    task automatic send(input logic [1:0] s, input logic [7:0] p, input int g, input string tag);
        sel = s;
        seg = p;
        repeat (g) @(posedge clk);
        @(negedge clk);
        m_idle += g;
        model(s, p);
        check_all(tag);
    endtask

    // the ones pattern held through reset becomes the first, leading ones capture
    task automatic do_reset();
        rst = 1'b1;
        sel = 2'b10;
        seg = 8'h5B;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.ten", ten, 0);
        chk("rst.one", one, 0);
        chk("rst.value", value, 0);
        chk("rst.valid", valid, 0);
        chk("rst.upd", upd, 0);
        chk("rst.err", err, 0);
        rst = 1'b0;
        m_last = 2'b00; m_have = 0; m_valid = 0; m_err = 0;
        m_ten = 0; m_one = 0; m_tens = 0; exp_upd = 0; m_idle = 0;
        frames.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        model(2'b10, 8'h5B);
        check_all("post_rst");
    endtask

    initial begin
        int u0;
        logic [1:0] s;
        do_reset();

        for (int i = 0; i < 2; i++) begin
            send(2'b01, 8'h30, 3, "lead.t");
            send(2'b10, 8'h6D, 3, "lead.o");
        end
        chk("lead.value12", value, 12);

        u0 = upd_cnt;
        for (int i = 0; i < 3; i++) begin
            send(2'b01, 8'h79, 20, "f34.t");
            send(2'b10, 8'h33, 20, "f34.o");
        end
        chk("f34.value", value, 34);
        chk("f34.valid", valid, 1);
        chk("f34.one_upd", upd_cnt - u0, 1);
        chk("f34.err", err, 0);

        send(2'b01, 8'h79, 3, "f35a.t");
        send(2'b10, 8'h5B, 3, "f35a.o");
        chk("f35a.hold34", value, 34);
        u0 = upd_cnt;
        send(2'b01, 8'h79, 3, "f35b.t");
        send(2'b10, 8'h5B, 3, "f35b.o");
        chk("f35b.value", value, 35);
        chk("f35b.upd", upd_cnt - u0, 1);

        for (int i = 0; i < 2; i++) begin
            send(2'b01, 8'h79, 3, "to.t");
            send(2'b10, 8'h33, 3, "to.o");
        end
        send(2'b01, 8'h79, 3, "to.partial");
        u0 = upd_cnt;
        repeat (TO - 3) @(posedge clk);
        @(negedge clk);
        chk("to.still_valid", valid, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("to.valid_fell", valid, 0);
        chk("to.value_held", value, 34);
        chk("to.no_upd", upd_cnt - u0, 0);
        m_valid = 0; m_have = 0; m_idle = 0;
        frames.delete();
        send(2'b10, 8'h33, 3, "to.orphan_one");
        send(2'b01, 8'h79, 3, "to.r1t");
        send(2'b10, 8'h33, 3, "to.r1o");
        chk("to.needs_two", valid, 0);
        send(2'b01, 8'h79, 3, "to.r2t");
        send(2'b10, 8'h33, 3, "to.r2o");
        chk("to.revalid", valid, 1);

        for (int i = 0; i < 2; i++) begin
            send(2'b01, 8'h4F, 3, "e.t");
            send(2'b10, 8'h7E, 3, "e.o");
        end
        chk("e.ten", ten, 4'hE);
        chk("e.value", value, 127);
        chk("e.err", err, 0);

        for (int i = 0; i < 200; i++) begin
            s = ($urandom_range(0, 7) == 0 && m_idle < 30) ? m_last : ~m_last;
            send(s, pool[$urandom_range(0, 3)], $urandom_range(2, 6), "rnd");
        end

        send(2'b11, 8'h7E, 2, "ill.sel");
        chk("ill.err", err, 1);
        send(2'b10, 8'h00, 3, "ill.seg");
        send(2'b01, 8'h7E, 3, "ill.sticky");
        chk("ill.sticky_err", err, 1);
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
